// File: rtl/lx_mem_scheduler.sv
// Round-robin arbiter sharing one 128-bit iomem port between icache fills and
// dcache fills/writes; one transaction in flight, with a watchdog on the memory ack.
module lx_mem_scheduler #(
    parameter int XLEN     = 32,
    parameter int BLK_SIZE = 128,
    parameter int WSTRB_W  = 16,
    parameter int MAX_WAIT = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ireq_valid_i,
    input  logic [XLEN-1:0]     ireq_addr_i,
    output logic                ireq_ready_o,
    output logic                ires_valid_o,
    output logic [BLK_SIZE-1:0] ires_data_o,
    input  logic                dreq_valid_i,
    input  logic [XLEN-1:0]     dreq_addr_i,
    input  logic [WSTRB_W-1:0]  dreq_wstrb_i,
    input  logic [BLK_SIZE-1:0] dreq_wdata_i,
    output logic                dreq_ready_o,
    output logic                dres_valid_o,
    output logic [BLK_SIZE-1:0] dres_data_o,
    output logic                mem_valid_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [WSTRB_W-1:0]  mem_wstrb_o,
    output logic [BLK_SIZE-1:0] mem_wdata_o,
    input  logic                mem_ready_i,
    input  logic [BLK_SIZE-1:0] mem_rdata_i,
    output logic                busy_o,
    output logic                timeout_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic                  last_d_reg, last_d_next;
    logic                  owner_d_reg, owner_d_next;
    logic [XLEN-1:0]       addr_reg, addr_next;
    logic [WSTRB_W-1:0]    wstrb_reg, wstrb_next;
    logic [BLK_SIZE-1:0]   wdata_reg, wdata_next;
    logic [BLK_SIZE-1:0]   rdata_reg, rdata_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  grant_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= ST_IDLE;
            last_d_reg  <= 1'b0;
            owner_d_reg <= 1'b0;
            addr_reg    <= '0;
            wstrb_reg   <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            last_d_reg  <= last_d_next;
            owner_d_reg <= owner_d_next;
            addr_reg    <= addr_next;
            wstrb_reg   <= wstrb_next;
            wdata_reg   <= wdata_next;
            rdata_reg   <= rdata_next;
            cnt_reg     <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        last_d_next  = last_d_reg;
        owner_d_next = owner_d_reg;
        addr_next    = addr_reg;
        wstrb_next   = wstrb_reg;
        wdata_next   = wdata_reg;
        rdata_next   = rdata_reg;
        cnt_next     = cnt_reg;
        grant_d      = 1'b0;
        ireq_ready_o = 1'b0;
        dreq_ready_o = 1'b0;
        timeout_o    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Ready pulses are combinational, so keep them quiet while reset is held.
                if (rst_ni && (ireq_valid_i || dreq_valid_i)) begin
                    grant_d      = dreq_valid_i && (!ireq_valid_i || !last_d_reg);
                    ireq_ready_o = !grant_d;
                    dreq_ready_o = grant_d;
                    owner_d_next = grant_d;
                    addr_next    = grant_d ? dreq_addr_i  : ireq_addr_i;
                    wstrb_next   = grant_d ? dreq_wstrb_i : '0;
                    wdata_next   = grant_d ? dreq_wdata_i : '0;
                    cnt_next     = '0;
                    state_next   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_next = cnt_reg + 1'b1;
                if (mem_ready_i) begin
                    rdata_next = mem_rdata_i;
                    state_next = ST_RESP;
                end else if (cnt_next == CNT_MAX) begin
                    // Watchdog: retire the transaction with an all-zero line.
                    rdata_next = '0;
                    timeout_o  = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                last_d_next = owner_d_reg;
                cnt_next    = '0;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy_o       = (state_reg != ST_IDLE);
    assign mem_valid_o  = (state_reg == ST_BUSY);
    assign mem_addr_o   = mem_valid_o ? addr_reg  : '0;
    assign mem_wstrb_o  = mem_valid_o ? wstrb_reg : '0;
    assign mem_wdata_o  = mem_valid_o ? wdata_reg : '0;

    assign ires_valid_o = (state_reg == ST_RESP) && !owner_d_reg;
    assign dres_valid_o = (state_reg == ST_RESP) && owner_d_reg;
    assign ires_data_o  = ires_valid_o ? rdata_reg : '0;
    assign dres_data_o  = dres_valid_o ? rdata_reg : '0;

endmodule

// File: tb/tb_lx_mem_scheduler.sv
// Directed bench for lx_mem_scheduler: stimulus pushes expected responses,
// a negedge monitor pops and compares them when a res_valid pulse appears.
module tb_lx_mem_scheduler;

    localparam int XLEN     = 32;
    localparam int BLK_SIZE = 128;
    localparam int WSTRB_W  = 16;
    localparam int MAX_WAIT = 8;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                ireq_valid_i;
    logic [XLEN-1:0]     ireq_addr_i;
    logic                ireq_ready_o;
    logic                ires_valid_o;
    logic [BLK_SIZE-1:0] ires_data_o;
    logic                dreq_valid_i;
    logic [XLEN-1:0]     dreq_addr_i;
    logic [WSTRB_W-1:0]  dreq_wstrb_i;
    logic [BLK_SIZE-1:0] dreq_wdata_i;
    logic                dreq_ready_o;
    logic                dres_valid_o;
    logic [BLK_SIZE-1:0] dres_data_o;
    logic                mem_valid_o;
    logic [XLEN-1:0]     mem_addr_o;
    logic [WSTRB_W-1:0]  mem_wstrb_o;
    logic [BLK_SIZE-1:0] mem_wdata_o;
    logic                mem_ready_i;
    logic [BLK_SIZE-1:0] mem_rdata_i;
    logic                busy_o;
    logic                timeout_o;

    lx_mem_scheduler #(
        .XLEN(XLEN), .BLK_SIZE(BLK_SIZE), .WSTRB_W(WSTRB_W), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ireq_valid_i(ireq_valid_i), .ireq_addr_i(ireq_addr_i), .ireq_ready_o(ireq_ready_o),
        .ires_valid_o(ires_valid_o), .ires_data_o(ires_data_o),
        .dreq_valid_i(dreq_valid_i), .dreq_addr_i(dreq_addr_i), .dreq_wstrb_i(dreq_wstrb_i),
        .dreq_wdata_i(dreq_wdata_i), .dreq_ready_o(dreq_ready_o),
        .dres_valid_o(dres_valid_o), .dres_data_o(dres_data_o),
        .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int resp_seen = 0;
    int resp_exp  = 0;

    typedef struct {
        logic                owner_d;
        logic [BLK_SIZE-1:0] data;
    } resp_t;
    resp_t sb_q[$];

    task automatic chk(input string name, input logic [BLK_SIZE-1:0] act,
                       input logic [BLK_SIZE-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk_i) begin
        if (ires_valid_o || dres_valid_o) begin
            resp_t r;
            resp_seen++;
            chk("resp_onehot", {127'd0, ires_valid_o && dres_valid_o}, '0);
            if (sb_q.size() == 0) begin
                chk("resp_unexpected", 1, 0);
            end else begin
                r = sb_q.pop_front();
                chk("resp_owner_d", {127'd0, dres_valid_o}, {127'd0, r.owner_d});
                chk("resp_data", dres_valid_o ? dres_data_o : ires_data_o, r.data);
                $display("resp: owner=%s data=%h", r.owner_d ? "d" : "i",
                         dres_valid_o ? dres_data_o : ires_data_o);
            end
        end
    end

    // Serve one transaction whose request is already driven; lat = BUSY cycles.
    task automatic serve(input logic exp_d, input logic [XLEN-1:0] exp_addr,
                         input logic [WSTRB_W-1:0] exp_wstrb,
                         input logic [BLK_SIZE-1:0] exp_wdata, input int lat,
                         input logic [BLK_SIZE-1:0] rdata, input logic to);
        resp_t r;
        int w = 0;
        @(negedge clk_i);
        while (!(ireq_ready_o || dreq_ready_o) && w < 20) begin
            @(negedge clk_i);
            w++;
        end
        if (w >= 20) begin
            chk("grant_timeout", 1, 0);
            return;
        end
        chk("grant_d", {127'd0, dreq_ready_o}, {127'd0, exp_d});
        chk("grant_i", {127'd0, ireq_ready_o}, {127'd0, !exp_d});
        chk("grant_idle_busy", {127'd0, busy_o}, '0);
        r.owner_d = exp_d;
        r.data    = to ? '0 : rdata;
        sb_q.push_back(r);
        resp_exp++;
        $display("grant: owner=%s addr=%h lat=%0d to=%0d", exp_d ? "d" : "i", exp_addr, lat, to);
        @(posedge clk_i); #1;
        if (exp_d) begin
            dreq_valid_i = 1'b0;
            dreq_addr_i  = 32'hDEAD_0000;
            dreq_wdata_i = {4{32'hBAD0BAD0}};
        end else begin
            ireq_valid_i = 1'b0;
            ireq_addr_i  = 32'hDEAD_1111;
        end
        for (int i = 1; i <= lat; i++) begin
            if (i == lat && !to) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = rdata;
            end
            @(negedge clk_i);
            chk("mem_valid", {127'd0, mem_valid_o}, 1);
            chk("mem_addr", {96'd0, mem_addr_o}, {96'd0, exp_addr});
            chk("mem_wstrb", {112'd0, mem_wstrb_o}, {112'd0, exp_wstrb});
            chk("mem_wdata", mem_wdata_o, exp_wdata);
            chk("timeout", {127'd0, timeout_o}, {127'd0, to && (i == lat)});
            @(posedge clk_i); #1;
            mem_ready_i = 1'b0;
            mem_rdata_i = '0;
        end
        @(negedge clk_i);
        chk("resp_ires", {127'd0, ires_valid_o}, {127'd0, !exp_d});
        chk("resp_dres", {127'd0, dres_valid_o}, {127'd0, exp_d});
        chk("resp_mem_valid", {127'd0, mem_valid_o}, '0);
        chk("resp_mem_addr", {96'd0, mem_addr_o}, '0);
        chk("resp_busy", {127'd0, busy_o}, 1);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_ni       = 1'b0;
        ireq_valid_i = 1'b0;
        ireq_addr_i  = '0;
        dreq_valid_i = 1'b0;
        dreq_addr_i  = '0;
        dreq_wstrb_i = '0;
        dreq_wdata_i = '0;
        mem_ready_i  = 1'b0;
        mem_rdata_i  = '0;
        #3;
        chk("rst_busy", {127'd0, busy_o}, '0);
        chk("rst_mem_valid", {127'd0, mem_valid_o}, '0);
        chk("rst_ready", {126'd0, ireq_ready_o, dreq_ready_o}, '0);
        chk("rst_res", {126'd0, ires_valid_o, dres_valid_o}, '0);
        chk("rst_timeout", {127'd0, timeout_o}, '0);
        @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;

        // Single icache read, ready after 3 BUSY cycles
        @(posedge clk_i); #1;
        ireq_valid_i = 1'b1;
        ireq_addr_i  = 32'h1000;
        serve(1'b0, 32'h1000, '0, '0, 3, {16{8'hA5}}, 1'b0);

        // Conflicts alternate strictly, dcache first
        ireq_valid_i = 1'b1; ireq_addr_i = 32'h2000;
        dreq_valid_i = 1'b1; dreq_addr_i = 32'h3000; dreq_wstrb_i = '0; dreq_wdata_i = '0;
        for (int r = 0; r < 4; r++) begin
            logic d;
            d = (r % 2 == 0);
            serve(d, d ? 32'h3000 : 32'h2000, '0, '0, 1 + r, {4{32'h0C0D_0000 + r}}, 1'b0);
            if (d) begin
                dreq_valid_i = 1'b1; dreq_addr_i = 32'h3000; dreq_wdata_i = '0;
            end else begin
                ireq_valid_i = 1'b1; ireq_addr_i = 32'h2000;
            end
        end
        ireq_valid_i = 1'b0;
        dreq_valid_i = 1'b0;

        // dcache write
        @(posedge clk_i); #1;
        dreq_valid_i = 1'b1;
        dreq_addr_i  = 32'h4000;
        dreq_wstrb_i = 16'hFFFF;
        dreq_wdata_i = {4{32'h12345678}};
        serve(1'b1, 32'h4000, 16'hFFFF, {4{32'h12345678}}, 3, {4{32'h0000_5A5A}}, 1'b0);
        dreq_wstrb_i = '0;

        // Memory never acknowledges
        ireq_valid_i = 1'b1;
        ireq_addr_i  = 32'h5000;
        serve(1'b0, 32'h5000, '0, '0, MAX_WAIT, '0, 1'b1);
        @(negedge clk_i);
        chk("to_busy_clear", {127'd0, busy_o}, '0);

        // mem_ready_i while idle is ignored
        @(posedge clk_i); #1;
        mem_ready_i = 1'b1;
        mem_rdata_i = {16{8'hEE}};
        @(negedge clk_i);
        chk("idle_rdy_busy", {127'd0, busy_o}, '0);
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        @(negedge clk_i);
        chk("idle_rdy_busy2", {127'd0, busy_o}, '0);
        chk("idle_rdy_res", {126'd0, ires_valid_o, dres_valid_o}, '0);

        // Reset in the middle of BUSY
        @(posedge clk_i); #1;
        ireq_valid_i = 1'b1;
        ireq_addr_i  = 32'h7000;
        @(negedge clk_i);
        chk("rb_grant", {127'd0, ireq_ready_o}, 1);
        @(posedge clk_i); #1;
        ireq_valid_i = 1'b0;
        @(negedge clk_i);
        chk("rb_mem_valid_pre", {127'd0, mem_valid_o}, 1);
        #2;
        rst_ni       = 1'b0;
        ireq_valid_i = 1'b1;
        #1;
        chk("rb_mem_valid", {127'd0, mem_valid_o}, '0);
        chk("rb_mem_addr", {96'd0, mem_addr_o}, '0);
        chk("rb_busy", {127'd0, busy_o}, '0);
        chk("rb_ready", {126'd0, ireq_ready_o, dreq_ready_o}, '0);
        chk("rb_res", {126'd0, ires_valid_o, dres_valid_o}, '0);
        ireq_valid_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        ireq_valid_i = 1'b1;
        ireq_addr_i  = 32'h6000;
        serve(1'b0, 32'h6000, '0, '0, 1, {4{32'hCAFE_F00D}}, 1'b0);

        repeat (2) @(negedge clk_i);
        chk("sb_empty", {96'd0, 32'(sb_q.size())}, '0);
        chk("resp_count", {96'd0, 32'(resp_seen)}, {96'd0, 32'(resp_exp)});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
